// File: rtl/arm_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_mem_pkg
//  Description : Shared types and constants for the data-memory SRAM path.
//                Holds the controller state encoding, the SRAM bus widths
//                and the default byte address of data-memory word 0.
//  Revision    : 1.0 - initial release
// ============================================================================
package arm_mem_pkg;

    localparam int          SRAM_ADDR_W         = 18;
    localparam int          SRAM_DATA_W         = 16;
    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;
    localparam int          DEFAULT_WAIT_CYCLES = 5;

    // IDLE -> LOW (low half-word) -> HIGH (high half-word) -> DONE -> IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_wait_counter
//  Description : 4-bit wait-state counter shared by both half-word phases.
//                Clear has priority over enable. o_terminal flags the last
//                count (WAIT_CYCLES-1) of a phase.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_clear       - force the count back to zero
//                i_enable      - advance the count by one
//                o_count       - current count
//                o_terminal    - high when o_count == WAIT_CYCLES-1
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_counter
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_enable,
    output logic [3:0] o_count,
    output logic       o_terminal
);

    localparam logic [3:0] c_last = 4'(WAIT_CYCLES - 1);

    logic [3:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (i_clear) begin
            r_count <= 4'd0;
        end else if (i_enable) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller
//  Description : Turns each 32-bit MEM-stage load/store into two 16-bit
//                accesses to an asynchronous SRAM (low half, then high half),
//                each held for WAIT_CYCLES cycles. ready is low while an
//                access is in flight and is used to freeze the pipeline.
//  Ports       : clk, rst               - clock, async active-high reset
//                mem_r_en, mem_w_en     - load / store request
//                address, write_data    - byte address, store data
//                read_data              - load result (registered)
//                ready                  - no access pending
//                sram_addr              - SRAM half-word address
//                sram_dq_out/oe/in      - pad data out, output enable, in
//                sram_we_n/ce_n/oe_n/ub_n/lb_n - active-low SRAM strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    // Count value one before the last: the registered we_n must rise on
    // entry to the last count, so it is decided one cycle early.
    localparam logic [3:0] c_pre_last = 4'(WAIT_CYCLES - 2);

    mem_state_t                  r_state;
    logic                        r_write;
    logic [SRAM_ADDR_W-2:0]      r_word;
    logic [31:0]                 r_wdata;
    logic [SRAM_DATA_W-1:0]      r_low_buf;

    logic [31:0]                 w_offset;
    logic [SRAM_ADDR_W-2:0]      w_word;
    logic                        w_busy;
    logic [3:0]                  w_count;
    logic                        w_terminal;
    logic                        w_pre_last;
    logic                        w_unused_offset;

    // Word index relative to data memory; bits above the SRAM range and the
    // byte offset are dropped without any range check.
    assign w_offset        = address - BASE_ADDR;
    assign w_word          = w_offset[SRAM_ADDR_W:2];
    assign w_unused_offset = ^{w_offset[31:SRAM_ADDR_W+1], w_offset[1:0]};

    assign w_busy     = (r_state == LOW) || (r_state == HIGH);
    assign w_pre_last = (w_count == c_pre_last);

    // Counter restarts at zero for each half: cleared outside the busy
    // phases and on the terminal count of a phase.
    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (~w_busy | w_terminal),
        .i_enable   (w_busy),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    // ready drops in the same cycle a request appears in IDLE so the
    // pipeline freezes before the request edge.
    assign ready = (r_state == IDLE) ? ~(mem_r_en | mem_w_en)
                                     : (r_state == DONE);

    // SRAM outputs are loaded with the value for the *next* cycle so that
    // they are glitch-free registers aligned with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_low_buf   <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mem_w_en | mem_r_en) begin
                        // Store wins when both enables are high.
                        r_state     <= LOW;
                        r_write     <= mem_w_en;
                        r_word      <= w_word;
                        r_wdata     <= write_data;
                        sram_addr   <= {w_word, 1'b0};
                        sram_ce_n   <= 1'b0;
                        sram_ub_n   <= 1'b0;
                        sram_lb_n   <= 1'b0;
                        sram_oe_n   <= mem_w_en;
                        sram_we_n   <= ~mem_w_en;
                        sram_dq_oe  <= mem_w_en;
                        sram_dq_out <= mem_w_en ? write_data[15:0] : '0;
                    end
                end

                LOW: begin
                    if (w_terminal) begin
                        r_state     <= HIGH;
                        r_low_buf   <= sram_dq_in;
                        sram_addr   <= {r_word, 1'b1};
                        sram_we_n   <= ~r_write;
                        sram_dq_out <= r_write ? r_wdata[31:16] : '0;
                    end else begin
                        sram_we_n   <= ~r_write | w_pre_last;
                    end
                end

                HIGH: begin
                    if (w_terminal) begin
                        r_state    <= DONE;
                        if (!r_write) begin
                            read_data <= {sram_dq_in, r_low_buf};
                        end
                        sram_ce_n  <= 1'b1;
                        sram_ub_n  <= 1'b1;
                        sram_lb_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                    end else begin
                        sram_we_n  <= ~r_write | w_pre_last;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller between the MEM stage and an off-chip 16-bit asynchronous SRAM holding data memory. Each 32-bit load/store from the MEM stage becomes two 16-bit SRAM accesses (low half, then high half), each held for a fixed number of wait cycles. `ready` is low while an access is in flight; the top level ORs `~ready` into the pipeline freeze so IF through MEM hold until the access completes.

## Interface
- `BASE_ADDR`, default 1024: byte address of data memory word 0; subtracted from `address`.
- `WAIT_CYCLES`, default 5: cycles each half-word access is held; legal range 2..15.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_r_en`  in  1  load request from the MEM stage.
- `mem_w_en`  in  1  store request from the MEM stage.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (val_rm).
- `read_data`  out  32  load result.
- `ready`  out  1  high when no access is pending.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq_out`  out  16  write data to the pad.
- `sram_dq_oe`  out  1  pad output enable (drive `sram_dq_out`).
- `sram_dq_in`  in  16  read data from the pad.
- `sram_we_n`, `sram_ce_n`, `sram_oe_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  active-low SRAM controls.

## Operation
- Address map: word = (address − BASE_ADDR) >> 2. Half h ∈ {0, 1}: sram_addr = {word[16:0], h}. Bits above are ignored; there is no range check.
- FSM states:
  - IDLE: on mem_w_en → LOW. Otherwise on mem_r_en → LOW. Otherwise stay.
  - LOW: wait counter runs 0..WAIT_CYCLES−1; at WAIT_CYCLES−1 → HIGH.
  - HIGH: same count; at WAIT_CYCLES−1 → DONE.
  - DONE: → IDLE unconditionally.
- Access type is latched in IDLE (write takes priority if both enables are high), together with address and write_data. Inputs are not re-sampled until the next IDLE.
- ready:
  - IDLE: = ~(mem_r_en | mem_w_en), combinational.
  - LOW/HIGH: 0.
  - DONE: 1.
- SRAM controls:
  - sram_ce_n, sram_ub_n, sram_lb_n = 0 in LOW/HIGH; 1 otherwise.
  - Read: sram_oe_n = 0 in LOW/HIGH. sram_dq_oe = 0.
  - Write: sram_oe_n = 1. sram_dq_oe = 1 in LOW/HIGH. sram_dq_out = write_data[15:0] in LOW, [31:16] in HIGH. sram_we_n = 0 for counts 0..WAIT_CYCLES−2 and 1 on the last count, so the address and data are stable when we_n rises.
- Read data: sram_dq_in is captured into low_buf on the last LOW cycle. On the last HIGH cycle, read_data <= {sram_dq_in, low_buf}. read_data holds until the next read completes; writes leave it unchanged.
- Reset (any time, including mid-access):
  - FSM → IDLE, counter → 0, read_data → 0, low_buf → 0.
  - All `_n` outputs → 1, sram_dq_oe → 0, sram_addr → 0, sram_dq_out → 0.
  - The in-flight access is abandoned.

## Timing
- Request visible in IDLE at cycle 0: ready is low in the same cycle (combinational).
- LOW occupies cycles 1..W, HIGH occupies W+1..2W, and DONE is cycle 2W+1 with ready = 1. W = WAIT_CYCLES.
- The pipeline advances on the edge ending DONE. The request seen in IDLE at 2W+2 is the next instruction's; back-to-back accesses therefore cost 2W+2 cycles each.
- read_data is valid from the DONE cycle onward (registered). The MEM stage register captures it on the DONE edge.
- All SRAM outputs are registered, or decoded only from state and counter; there is no glitching path from inputs.

## Structure
- Shared package `arm_mem_pkg`:
  - state enum {IDLE, LOW, HIGH, DONE}
  - `SRAM_ADDR_W` = 18
  - `SRAM_DATA_W` = 16
  - default `BASE_ADDR`
- One sub-module, `sram_wait_counter`: 4-bit counter with clear and enable, and a terminal flag at WAIT_CYCLES−1. It is reused by both half phases.
- Pad tristate (`inout`) lives at the board top, not in this block.

## Test plan
- Reset asserted mid-HIGH of a write → next cycle FSM IDLE, sram_we_n = 1, sram_dq_oe = 0, ready = 1, read_data = 0.
- Write address 1024, data 0xDEAD_BEEF, W = 5:
  - ready is low for cycles 0..10.
  - sram_addr = 0 with dq 0xBEEF, then 1 with dq 0xDEAD.
  - we_n is low for 4 cycles in each half.
  - ready = 1 at cycle 11.
- Read back address 1024 with the SRAM model → read_data = 0xDEADBEEF in DONE (cycle 11); sram_oe_n low for 10 cycles; dq_oe stays 0.
- Write 0x1234_5678 to address 1028, then an immediate read of 1028 with no idle gap:
  - half addresses are 2/3;
  - second ready rises 12 cycles after the first;
  - read_data = 0x12345678.
- mem_r_en and mem_w_en both high at address 1032 → write performed, read_data unchanged.
- address or enables changed while in LOW → no change to sram_addr or data until the next IDLE.
